// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type and default operand width for the Booth multiplier
package booth_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
endpackage

// File: rtl/booth_datapath.sv
// booth_datapath: A/Q/Q_1/M registers with add/subtract and arithmetic right shift for radix-2 Booth
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk_100M,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_add,
  input  logic               i_sub,
  input  logic               i_shift,
  input  logic [WIDTH-1:0]   i_m,
  input  logic [WIDTH-1:0]   i_q,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [1:0]         o_pair
);
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_q_1;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_sum   = i_sub ? r_a - w_m_ext : r_a + w_m_ext;
  assign o_prod  = {r_a[WIDTH-1:0], r_q};
  assign o_pair  = {r_q[0], r_q_1};
  // Load operands, accumulate +/-M, or shift {A,Q,Q_1} right with A's sign replicated
  always_ff @(posedge Clk_100M) begin
    if (reset || i_clear) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_q_1 <= 1'b0;
    end else if (i_load) begin
      r_a   <= '0;
      r_q   <= i_q;
      r_m   <= i_m;
      r_q_1 <= 1'b0;
    end else if (i_add || i_sub) begin
      r_a <= w_sum;
    end else if (i_shift) begin
      r_a   <= {r_a[WIDTH], r_a[WIDTH:1]};
      r_q   <= {r_a[0], r_q[WIDTH-1:1]};
      r_q_1 <= r_q[0];
    end
  end
endmodule

// File: rtl/booth_sequencer.sv
// booth_sequencer: sequential signed Booth multiplier started by a push-button edge; BOOTH_ZERO_BYPASS_EN skips zero operands
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk_100M,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t            r_state;
  state_t            w_next;
  logic              r_start_prev;
  logic [CW-1:0]     r_count;
  logic              w_edge;
  logic              w_zero;
  logic              w_load;
  logic              w_clear;
  logic              w_add;
  logic              w_sub;
  logic              w_shift;
  logic [2*WIDTH-1:0] w_prod;
  logic [1:0]        w_pair;
  assign w_edge = start & ~r_start_prev;
  assign busy   = r_state != IDLE;
`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_zero = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero = 1'b0;
`endif
  booth_datapath #(.WIDTH(WIDTH)) u_dp (
    .Clk_100M(Clk_100M),
    .reset(reset),
    .i_load(w_load),
    .i_clear(w_clear),
    .i_add(w_add),
    .i_sub(w_sub),
    .i_shift(w_shift),
    .i_m(multiplicand),
    .i_q(multiplier),
    .o_prod(w_prod),
    .o_pair(w_pair)
  );
  // Next state and datapath strobes; EVAL picks add/sub from the Booth pair {Q[0],Q_1}
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_add   = 1'b0;
    w_sub   = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        w_load  = w_edge & ~w_zero;
        w_clear = w_edge & w_zero;
        w_next  = w_edge ? (w_zero ? DONE : EVAL) : IDLE;
      end
      EVAL: begin
        w_add  = w_pair == 2'b01;
        w_sub  = w_pair == 2'b10;
        w_next = SHIFT;
      end
      SHIFT: begin
        w_shift = 1'b1;
        w_next  = (r_count == CW'(1)) ? DONE : EVAL;
      end
      default: w_next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge Clk_100M) r_state <= reset ? IDLE : w_next;
  // Edge history, iteration count, and the registered result/completion pulse
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      r_start_prev <= 1'b1;
      r_count      <= '0;
      product      <= '0;
      done         <= 1'b0;
    end else begin
      r_start_prev <= start;
      r_count      <= w_load ? CW'(WIDTH) : w_shift ? r_count - CW'(1) : r_count;
      done         <= r_state == DONE;
      if (r_state == DONE) product <= w_prod;
    end
  end
endmodule
